// File: rtl/ex_mem_pkg.sv
// Shared types and default widths for the EX->MEM pipeline stage.
// Control bit positions follow the {reg_write, mem_to_reg, mem_read, mem_write} ordering.
package ex_mem_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int NUM_LANES_DEF = 4;
    localparam int LANE_W_DEF    = 32;
    localparam int RADDR_W_DEF   = 5;
    localparam int CNT_W_DEF     = 16;

    localparam int CTRL_W         = 4;
    localparam int CTRL_REG_WRITE = 3;
    localparam int CTRL_MEM_TO_REG = 2;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 0;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    // Payload layout at the default widths; the stage packs the same field order
    // into a flat vector so non-default parameters keep working.
    typedef struct packed {
        logic [XLEN_DEF-1:0]                 pc;
        logic [XLEN_DEF-1:0]                 instr;
        logic [XLEN_DEF-1:0]                 alu;
        logic [XLEN_DEF-1:0]                 rd_data;
        logic [NUM_LANES_DEF*LANE_W_DEF-1:0] valu;
        logic [NUM_LANES_DEF-1:0]            lane_en;
        logic [RADDR_W_DEF-1:0]              rd_addr;
        logic                                zero;
        ctrl_t                               ctrl;
    } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_stage_pipe_slot.sv
// Payload-wide register with load enable; the synchronous clear wins over load.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (ld_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM stage: valid/ready register with a one-entry skid, flush, bubble-masked
// control and a saturating stall counter. Output appears one cycle after acceptance.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int LANE_W    = LANE_W_DEF,
    parameter int RADDR_W   = RADDR_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    input  logic [XLEN-1:0]             s_pc_i,
    input  logic [XLEN-1:0]             s_instr_i,
    input  logic [XLEN-1:0]             s_alu_i,
    input  logic [XLEN-1:0]             s_rd_data_i,
    input  logic [NUM_LANES*LANE_W-1:0] s_valu_i,
    input  logic [NUM_LANES-1:0]        s_lane_en_i,
    input  logic [RADDR_W-1:0]          s_rd_addr_i,
    input  logic                        s_zero_i,
    input  logic [CTRL_W-1:0]           s_ctrl_i,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [XLEN-1:0]             m_pc_o,
    output logic [XLEN-1:0]             m_instr_o,
    output logic [XLEN-1:0]             m_alu_o,
    output logic [XLEN-1:0]             m_rd_data_o,
    output logic [NUM_LANES*LANE_W-1:0] m_valu_o,
    output logic [NUM_LANES-1:0]        m_lane_en_o,
    output logic [RADDR_W-1:0]          m_rd_addr_o,
    output logic                        m_zero_o,
    output logic [CTRL_W-1:0]           m_ctrl_o,
    output logic [CNT_W-1:0]            stall_cnt_o
);

    localparam int VW = NUM_LANES * LANE_W;
    localparam int PW = 4 * XLEN + VW + NUM_LANES + RADDR_W + 1 + CTRL_W;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    logic [1:0]       state_d, state_q;
    logic             s_ready_d, s_ready_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic             main_ld, skid_ld;
    logic             in_xfer, out_xfer;
    logic [VW-1:0]    valu_masked;
    logic [PW-1:0]    in_pl, main_in, main_pl, skid_pl;
    logic [CTRL_W-1:0] main_ctrl_raw;
    ctrl_t            main_ctrl;

    // Disabled lanes are stored as zero so stale lane data never reaches MEM.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane_mask
        assign valu_masked[k*LANE_W +: LANE_W] =
            s_lane_en_i[k] ? s_valu_i[k*LANE_W +: LANE_W] : '0;
    end

    assign in_pl = {s_pc_i, s_instr_i, s_alu_i, s_rd_data_i, valu_masked,
                    s_lane_en_i, s_rd_addr_i, s_zero_i, s_ctrl_i};

    assign m_valid_o = (state_q != ST_EMPTY);
    assign s_ready_o = s_ready_q;
    assign in_xfer   = s_valid_i & s_ready_q;
    assign out_xfer  = m_valid_o & m_ready_i;

    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d = ST_FULL;
                    main_ld = 1'b1;
                end
            end
            ST_FULL: begin
                if (in_xfer && out_xfer) begin
                    main_ld = 1'b1;
                end else if (in_xfer) begin
                    state_d = ST_SKID;
                    skid_ld = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_xfer) begin
                    state_d = ST_FULL;
                    main_ld = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush drops any concurrent load; slots keep their contents so m_* hold.
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_ld = 1'b0;
            skid_ld = 1'b0;
        end
        s_ready_d = (state_d != ST_SKID);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid_o && !m_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            s_ready_q   <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            s_ready_q   <= s_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign main_in = (state_q == ST_SKID) ? skid_pl : in_pl;

    pipe_slot #(.W(PW)) u_main (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .ld_i  (main_ld),
        .d_i   (main_in),
        .q_o   (main_pl)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .ld_i  (skid_ld),
        .d_i   (in_pl),
        .q_o   (skid_pl)
    );

    assign {m_pc_o, m_instr_o, m_alu_o, m_rd_data_o, m_valu_o,
            m_lane_en_o, m_rd_addr_o, m_zero_o, main_ctrl_raw} = main_pl;
    assign main_ctrl = ctrl_t'(main_ctrl_raw);

    // Bubbles present no memory or register-file side effects.
    always_comb begin
        m_ctrl_o = '0;
        if (m_valid_o) begin
            m_ctrl_o[CTRL_REG_WRITE]  = main_ctrl.reg_write;
            m_ctrl_o[CTRL_MEM_TO_REG] = main_ctrl.mem_to_reg;
            m_ctrl_o[CTRL_MEM_READ]   = main_ctrl.mem_read;
            m_ctrl_o[CTRL_MEM_WRITE]  = main_ctrl.mem_write;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: queue-based reference model compared every cycle,
// plus directed literal checks on the key scenarios.
module tb_ex_mem_stage;

    logic         clk_i = 1'b0;
    logic         rst_i, flush_i, s_valid_i, m_ready_i;
    logic         s_ready_o, m_valid_o, s_zero_i, m_zero_o;
    logic [31:0]  s_pc_i, s_instr_i, s_alu_i, s_rd_data_i;
    logic [31:0]  m_pc_o, m_instr_o, m_alu_o, m_rd_data_o;
    logic [127:0] s_valu_i, m_valu_o;
    logic [3:0]   s_lane_en_i, m_lane_en_o, s_ctrl_i, m_ctrl_o;
    logic [4:0]   s_rd_addr_i, m_rd_addr_o;
    logic [3:0]   stall_cnt_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    ex_mem_stage #(.XLEN(32), .NUM_LANES(4), .LANE_W(32), .RADDR_W(5), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .s_pc_i(s_pc_i), .s_instr_i(s_instr_i), .s_alu_i(s_alu_i), .s_rd_data_i(s_rd_data_i),
        .s_valu_i(s_valu_i), .s_lane_en_i(s_lane_en_i), .s_rd_addr_i(s_rd_addr_i),
        .s_zero_i(s_zero_i), .s_ctrl_i(s_ctrl_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_pc_o(m_pc_o), .m_instr_o(m_instr_o), .m_alu_o(m_alu_o), .m_rd_data_o(m_rd_data_o),
        .m_valu_o(m_valu_o), .m_lane_en_o(m_lane_en_o), .m_rd_addr_o(m_rd_addr_o),
        .m_zero_o(m_zero_o), .m_ctrl_o(m_ctrl_o), .stall_cnt_o(stall_cnt_o)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: an ordered queue of at most two accepted entries.
    typedef struct packed {
        logic [31:0]  pc, instr, alu, rd;
        logic [127:0] valu;
        logic [3:0]   en;
        logic [4:0]   rdaddr;
        logic         zero;
        logic [3:0]   ctrl;
    } pl_t;

    pl_t mq[$];
    pl_t shown;
    pl_t inp;
    bit  mdl_ready = 1'b1;
    bit  armed = 1'b0;
    bit  inx, outx;
    int  mcnt = 0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            mq.delete();
            shown = '0;
            mcnt = 0;
            mdl_ready = 1'b1;
            armed = 1'b1;
        end else if (armed) begin
            inp = '0;
            inp.pc = s_pc_i; inp.instr = s_instr_i; inp.alu = s_alu_i; inp.rd = s_rd_data_i;
            for (int k = 0; k < 4; k++)
                if (s_lane_en_i[k]) inp.valu[k*32 +: 32] = s_valu_i[k*32 +: 32];
            inp.en = s_lane_en_i; inp.rdaddr = s_rd_addr_i; inp.zero = s_zero_i; inp.ctrl = s_ctrl_i;
            inx  = s_valid_i && mdl_ready;
            outx = (mq.size() > 0) && m_ready_i;
            if (mq.size() > 0 && !m_ready_i && mcnt < 15) mcnt++;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (outx) void'(mq.pop_front());
                if (inx) mq.push_back(inp);
            end
            if (mq.size() > 0) shown = mq[0];
            mdl_ready = (mq.size() < 2);
        end
    end

    always @(negedge clk_i) begin
        if (armed) begin
            chk("m_valid",   128'(m_valid_o),   128'(mq.size() > 0));
            chk("s_ready",   128'(s_ready_o),   128'(mdl_ready));
            chk("stall_cnt", 128'(stall_cnt_o), 128'(mcnt));
            chk("m_ctrl",    128'(m_ctrl_o),    128'((mq.size() > 0) ? shown.ctrl : 4'h0));
            chk("m_pc",      128'(m_pc_o),      128'(shown.pc));
            chk("m_instr",   128'(m_instr_o),   128'(shown.instr));
            chk("m_alu",     128'(m_alu_o),     128'(shown.alu));
            chk("m_rd_data", 128'(m_rd_data_o), 128'(shown.rd));
            chk("m_valu",    m_valu_o,          shown.valu);
            chk("m_lane_en", 128'(m_lane_en_o), 128'(shown.en));
            chk("m_rd_addr", 128'(m_rd_addr_o), 128'(shown.rdaddr));
            chk("m_zero",    128'(m_zero_o),    128'(shown.zero));
        end
    end

    // Drive one cycle of input (from a negedge) and return at the next negedge.
    task automatic put(input logic v, input logic [31:0] pc, input logic [3:0] ctrl,
                       input logic [3:0] en, input logic [127:0] valu);
        s_valid_i   = v;
        s_pc_i      = pc;
        s_instr_i   = {pc[15:0], 16'h0013};
        s_alu_i     = pc + 32'h100;
        s_rd_data_i = ~pc;
        s_valu_i    = valu;
        s_lane_en_i = en;
        s_rd_addr_i = pc[6:2];
        s_zero_i    = pc[2];
        s_ctrl_i    = ctrl;
        @(negedge clk_i);
    endtask

    function automatic logic [127:0] vdef(input logic [31:0] pc);
        return {pc + 32'd3, pc + 32'd2, pc + 32'd1, pc};
    endfunction

    task automatic send(input logic [31:0] pc);
        put(1'b1, pc, 4'b1010, 4'hF, vdef(pc));
    endtask

    task automatic idle();
        put(1'b0, 32'h0, 4'b1111, 4'hF, 128'h0);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; m_ready_i = 1'b1;
        idle();
        idle();
        chk("rst_valid", 128'(m_valid_o), 128'(0));
        chk("rst_ready", 128'(s_ready_o), 128'(1));
        chk("rst_cnt",   128'(stall_cnt_o), 128'(0));
        chk("rst_ctrl",  128'(m_ctrl_o), 128'(0));
        rst_i = 1'b0;

        // Streaming
        send(32'h00); chk("str_pc0", 128'(m_pc_o), 128'(32'h00)); chk("str_v0", 128'(m_valid_o), 128'(1));
        send(32'h04); chk("str_pc1", 128'(m_pc_o), 128'(32'h04)); chk("str_rdy1", 128'(s_ready_o), 128'(1));
        send(32'h08); chk("str_pc2", 128'(m_pc_o), 128'(32'h08));
        idle();       chk("str_drain", 128'(m_valid_o), 128'(0));

        // Back-pressure into the skid slot
        m_ready_i = 1'b0;
        send(32'h10); chk("bp_rdy_a", 128'(s_ready_o), 128'(1));
        send(32'h14); chk("bp_rdy_b", 128'(s_ready_o), 128'(0)); chk("bp_pc_b", 128'(m_pc_o), 128'(32'h10));
        idle();
        idle();       chk("bp_cnt", 128'(stall_cnt_o), 128'(3)); chk("bp_pc_d", 128'(m_pc_o), 128'(32'h10));
        m_ready_i = 1'b1;
        idle();       chk("bp_pc_rel", 128'(m_pc_o), 128'(32'h14)); chk("bp_rdy_rel", 128'(s_ready_o), 128'(1));
        idle();       chk("bp_empty", 128'(m_valid_o), 128'(0));

        // Flush while in SKID with a concurrent valid input
        m_ready_i = 1'b0;
        send(32'h20);
        send(32'h24);
        flush_i = 1'b1;
        send(32'h28);
        chk("fl_valid", 128'(m_valid_o), 128'(0));
        chk("fl_ctrl",  128'(m_ctrl_o), 128'(0));
        chk("fl_ready", 128'(s_ready_o), 128'(1));
        flush_i = 1'b0; m_ready_i = 1'b1;
        idle();
        idle();
        chk("fl_gone", 128'(m_valid_o), 128'(0));
        chk("fl_hold", 128'(m_pc_o), 128'(32'h20));

        // Lane masking and bubble control
        put(1'b1, 32'h30, 4'b1001, 4'b0101,
            {32'hAAAA, 32'hBBBB, 32'hCCCC, 32'hDDDD});
        chk("ln_valu", m_valu_o, {32'h0, 32'hBBBB, 32'h0, 32'hDDDD});
        chk("ln_en",   128'(m_lane_en_o), 128'(4'b0101));
        chk("ln_ctrl", 128'(m_ctrl_o), 128'(4'b1001));
        idle();
        chk("bub_ctrl", 128'(m_ctrl_o), 128'(0));
        chk("bub_pc",   128'(m_pc_o), 128'(32'h30));

        // Saturation, then reset while in SKID
        rst_i = 1'b1;
        idle();
        rst_i = 1'b0;
        m_ready_i = 1'b0;
        send(32'h40);
        send(32'h44);
        for (int i = 0; i < 19; i++) idle();
        chk("sat_cnt",   128'(stall_cnt_o), 128'(15));
        chk("sat_ready", 128'(s_ready_o), 128'(0));
        rst_i = 1'b1;
        send(32'h48);
        chk("mr_valid", 128'(m_valid_o), 128'(0));
        chk("mr_ready", 128'(s_ready_o), 128'(1));
        chk("mr_cnt",   128'(stall_cnt_o), 128'(0));
        chk("mr_pc",    128'(m_pc_o), 128'(0));
        chk("mr_valu",  m_valu_o, 128'h0);
        rst_i = 1'b0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
